sched_encoder_32to5: RTL and testbench

Sequential 32-to-5 encoder: the inverse of the register-select decode path. Accepts a 32-bit request vector (e.g. pending register write-backs or interrupt lines) via valid/ready, then emits the 5-bit index of every set bit, one per handshake, in fixed priority order. Sits between request collectors and any consumer of 5-bit register or line numbers; its outputs feed the existing 5-to-32 decode path directly.

---
 rtl/sched_encoder_32to5_pkg.sv | 42 ++++
 rtl/sched_encoder_32to5_if.sv | 35 +++
 rtl/sched_encoder_32to5_prio.sv | 48 ++++
 rtl/sched_encoder_32to5.sv | 103 ++++++++++
 tb/tb_sched_encoder_32to5.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sched_encoder_32to5_pkg.sv
// Shared widths, state encoding and helper functions for the 32-to-5 scheduling encoder.
// SCHED_ENC_COUNT_EN adds the popcount helper used by the optional remaining-count output.
package sched_enc_pkg;

    localparam int VEC_W = 32;
    localparam int IDX_W = 5;
    localparam int CNT_W = 6;
    localparam int GRP_N = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // 8-to-3 priority encode; a zero input yields 0.
    function automatic logic [2:0] enc8(input logic [7:0] v, input bit low_first);
        logic [2:0] r;
        r = '0;
        if (low_first) begin
            for (int j = 7; j >= 0; j--) begin
                if (v[j]) r = 3'(j);
            end
        end else begin
            for (int j = 0; j < 8; j++) begin
                if (v[j]) r = 3'(j);
            end
        end
        return r;
    endfunction

`ifdef SCHED_ENC_COUNT_EN
    function automatic logic [CNT_W-1:0] popcount(input logic [0:VEC_W-1] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < VEC_W; i++) begin
            c = c + {{(CNT_W-1){1'b0}}, v[i]};
        end
        return c;
    endfunction
`endif

endpackage

// File: rtl/sched_encoder_32to5_if.sv
// Load/drain handshake bundle of the scheduling encoder.
// SCHED_ENC_COUNT_EN adds the cnt signal.
interface sched_encoder_32to5_if;
    import sched_enc_pkg::*;

    logic               load_valid;
    logic               load_ready;
    logic [0:VEC_W-1]   load_vec;
    logic               idx_valid;
    logic               idx_ready;
    logic [0:IDX_W-1]   idx;
    logic               idx_last;
    logic               done;
    logic               busy;
`ifdef SCHED_ENC_COUNT_EN
    logic [0:CNT_W-1]   cnt;
`endif

    modport master (
        output load_valid, load_vec, idx_ready,
        input  load_ready, idx_valid, idx, idx_last, done, busy
`ifdef SCHED_ENC_COUNT_EN
        , input cnt
`endif
    );

    modport slave (
        input  load_valid, load_vec, idx_ready,
        output load_ready, idx_valid, idx, idx_last, done, busy
`ifdef SCHED_ENC_COUNT_EN
        , output cnt
`endif
    );

endinterface

// File: rtl/sched_encoder_32to5_prio.sv
// Combinational 32-to-5 priority encoder: four 8-to-3 group encoders plus a 4-way
// group select, the mirror image of the 5-to-32 decode tree.
module prio_enc_32to5
    import sched_enc_pkg::*;
#(
    parameter bit LOW_FIRST = 1'b1
) (
    input  logic [0:VEC_W-1] vec,
    output logic [0:IDX_W-1] idx,
    output logic             any,
    output logic             one_hot
);

    logic [GRP_N-1:0]        g_any;
    logic [GRP_N-1:0]        g_multi;
    logic [GRP_N-1:0][2:0]   g_idx;
    logic [1:0]              gsel;

    for (genvar g = 0; g < GRP_N; g++) begin : g_grp
        logic [7:0] v8;
        always_comb begin
            v8 = '0;
            for (int j = 0; j < 8; j++) v8[j] = vec[8*g+j];
        end
        assign g_any[g]   = |v8;
        // v & (v-1) keeps anything beyond the lowest set bit
        assign g_multi[g] = |(v8 & (v8 - 8'd1));
        assign g_idx[g]   = enc8(v8, LOW_FIRST);
    end

    always_comb begin
        gsel = '0;
        if (LOW_FIRST) begin
            for (int g = GRP_N-1; g >= 0; g--) begin
                if (g_any[g]) gsel = 2'(g);
            end
        end else begin
            for (int g = 0; g < GRP_N; g++) begin
                if (g_any[g]) gsel = 2'(g);
            end
        end
    end

    assign idx     = {gsel, g_idx[gsel]};
    assign any     = |g_any;
    assign one_hot = $onehot(g_any) && !(|g_multi);

endmodule

// File: rtl/sched_encoder_32to5.sv
// Sequential 32-to-5 encoder: captures a request vector, then hands out one set-bit
// index per handshake in fixed priority order. SCHED_ENC_COUNT_EN adds the cnt output.
module sched_encoder_32to5
    import sched_enc_pkg::*;
#(
    parameter bit LOW_FIRST = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    sched_encoder_32to5_if.slave  bus
);

    state_t             state, state_nxt;
    logic [0:VEC_W-1]   pending, pending_nxt;
    logic               done_r, done_nxt;

    logic [0:IDX_W-1]   enc_idx;
    logic               enc_any;
    logic               enc_one;
    logic               idx_valid;
    logic               idx_last;
    logic               fire;

    prio_enc_32to5 #(.LOW_FIRST(LOW_FIRST)) u_prio (
        .vec     (pending),
        .idx     (enc_idx),
        .any     (enc_any),
        .one_hot (enc_one)
    );

    // Outputs depend only on registered state, so load_* never reaches idx_*.
    assign idx_valid      = (state == SCAN) && enc_any;
    assign idx_last       = idx_valid && enc_one;
    assign fire           = idx_valid && bus.idx_ready;

    assign bus.load_ready = (state == IDLE);
    assign bus.idx_valid  = idx_valid;
    assign bus.idx        = enc_idx;
    assign bus.idx_last   = idx_last;
    assign bus.done       = done_r;
    assign bus.busy       = (state == SCAN);

`ifdef SCHED_ENC_COUNT_EN
    logic [CNT_W-1:0] cnt_r, cnt_nxt;
    assign bus.cnt = cnt_r;
`endif

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        done_nxt    = 1'b0;
`ifdef SCHED_ENC_COUNT_EN
        cnt_nxt     = cnt_r;
`endif
        case (state)
            IDLE: begin
                if (bus.load_valid) begin
`ifdef SCHED_ENC_COUNT_EN
                    cnt_nxt = popcount(bus.load_vec);
`endif
                    if (|bus.load_vec) begin
                        pending_nxt = bus.load_vec;
                        state_nxt   = SCAN;
                    end else begin
                        done_nxt    = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (fire) begin
                    pending_nxt[enc_idx] = 1'b0;
`ifdef SCHED_ENC_COUNT_EN
                    cnt_nxt = cnt_r - 1'b1;
`endif
                    if (idx_last) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            pending <= '0;
            done_r  <= 1'b0;
`ifdef SCHED_ENC_COUNT_EN
            cnt_r   <= '0;
`endif
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
            done_r  <= done_nxt;
`ifdef SCHED_ENC_COUNT_EN
            cnt_r   <= cnt_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_sched_encoder_32to5.sv
// Directed bench for sched_encoder_32to5: a low-first and a high-first instance,
// inputs driven and outputs sampled on the falling edge.
module tb_sched_encoder_32to5;
    import sched_enc_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    sched_encoder_32to5_if bus_lo ();
    sched_encoder_32to5_if bus_hi ();

    sched_encoder_32to5 #(.LOW_FIRST(1'b1)) dut_lo (.clk(clk), .reset(reset), .bus(bus_lo));
    sched_encoder_32to5 #(.LOW_FIRST(1'b0)) dut_hi (.clk(clk), .reset(reset), .bus(bus_hi));

    function automatic logic [0:31] vec3();
        logic [0:31] v;
        v = '0;
        v[3] = 1'b1; v[17] = 1'b1; v[31] = 1'b1;
        return v;
    endfunction

    task automatic test_reset();
        bus_lo.load_valid = 0; bus_lo.load_vec = '0; bus_lo.idx_ready = 0;
        bus_hi.load_valid = 0; bus_hi.load_vec = '0; bus_hi.idx_ready = 0;
        reset = 1;
        repeat (2) @(negedge clk);
        n_chk++;
        if (bus_lo.load_ready !== 1'b1 || bus_lo.idx_valid !== 1'b0 || bus_lo.idx !== 5'd0 ||
            bus_lo.done !== 1'b0 || bus_lo.busy !== 1'b0 || bus_lo.idx_last !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_lo: rdy=%b vld=%b idx=%0d done=%b busy=%b last=%b, want 1 0 0 0 0 0",
                     bus_lo.load_ready, bus_lo.idx_valid, bus_lo.idx, bus_lo.done, bus_lo.busy, bus_lo.idx_last);
        end
        n_chk++;
        if (bus_hi.load_ready !== 1'b1 || bus_hi.idx_valid !== 1'b0 || bus_hi.done !== 1'b0 ||
            bus_hi.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hi: rdy=%b vld=%b done=%b busy=%b, want 1 0 0 0",
                     bus_hi.load_ready, bus_hi.idx_valid, bus_hi.done, bus_hi.busy);
        end
`ifdef SCHED_ENC_COUNT_EN
        n_chk++;
        if (bus_lo.cnt !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %0d want 0", bus_lo.cnt);
        end
`endif
        reset = 0;
        @(negedge clk);
    endtask

    // Three set bits drained back to back, then done with load_ready.
    task automatic test_drain();
        int exp_idx[3] = '{3, 17, 31};
        bus_lo.load_vec = vec3(); bus_lo.load_valid = 1; bus_lo.idx_ready = 1;
        @(negedge clk);
        bus_lo.load_valid = 0; bus_lo.load_vec = '0;
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (bus_lo.idx_valid !== 1'b1 || bus_lo.idx !== 5'(exp_idx[k]) ||
                bus_lo.idx_last !== (k == 2) || bus_lo.load_ready !== 1'b0 || bus_lo.busy !== 1'b1) begin
                n_fail++;
                $display("FAIL drain_%0d: vld=%b idx=%0d last=%b rdy=%b busy=%b, want 1 %0d %0d 0 1",
                         k, bus_lo.idx_valid, bus_lo.idx, bus_lo.idx_last, bus_lo.load_ready,
                         bus_lo.busy, exp_idx[k], (k == 2));
            end
`ifdef SCHED_ENC_COUNT_EN
            n_chk++;
            if (bus_lo.cnt !== 6'(3 - k)) begin
                n_fail++;
                $display("FAIL drain_cnt_%0d: got %0d want %0d", k, bus_lo.cnt, 3 - k);
            end
`endif
            @(negedge clk);
        end
        n_chk++;
        if (bus_lo.done !== 1'b1 || bus_lo.load_ready !== 1'b1 || bus_lo.idx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_done: done=%b rdy=%b vld=%b, want 1 1 0",
                     bus_lo.done, bus_lo.load_ready, bus_lo.idx_valid);
        end
`ifdef SCHED_ENC_COUNT_EN
        n_chk++;
        if (bus_lo.cnt !== 6'd0) begin
            n_fail++;
            $display("FAIL drain_cnt_done: got %0d want 0", bus_lo.cnt);
        end
`endif
        @(negedge clk);
        n_chk++;
        if (bus_lo.done !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_done_pulse: done=%b want 0", bus_lo.done);
        end
    endtask

    // idx held under back-pressure; load pulses in SCAN must not alter pending.
    task automatic test_stall();
        logic [0:31] intruder;
        int exp_idx[3] = '{3, 17, 31};
        intruder = '0; intruder[0] = 1'b1;
        bus_lo.load_vec = vec3(); bus_lo.load_valid = 1; bus_lo.idx_ready = 0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (bus_lo.idx_valid !== 1'b1 || bus_lo.idx !== 5'd3 || bus_lo.idx_last !== 1'b0 ||
                bus_lo.load_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold_%0d: vld=%b idx=%0d last=%b rdy=%b, want 1 3 0 0",
                         k, bus_lo.idx_valid, bus_lo.idx, bus_lo.idx_last, bus_lo.load_ready);
            end
            bus_lo.load_vec = intruder; bus_lo.load_valid = 1;
            @(negedge clk);
        end
        bus_lo.load_valid = 0; bus_lo.load_vec = '0; bus_lo.idx_ready = 1;
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (bus_lo.idx_valid !== 1'b1 || bus_lo.idx !== 5'(exp_idx[k]) || bus_lo.idx_last !== (k == 2)) begin
                n_fail++;
                $display("FAIL stall_resume_%0d: vld=%b idx=%0d last=%b, want 1 %0d %0d",
                         k, bus_lo.idx_valid, bus_lo.idx, bus_lo.idx_last, exp_idx[k], (k == 2));
            end
            @(negedge clk);
        end
        n_chk++;
        if (bus_lo.done !== 1'b1 || bus_lo.idx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_done: done=%b vld=%b, want 1 0", bus_lo.done, bus_lo.idx_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_zero_vec();
        bus_lo.load_vec = '0; bus_lo.load_valid = 1; bus_lo.idx_ready = 1;
        @(negedge clk);
        bus_lo.load_valid = 0;
        n_chk++;
        if (bus_lo.done !== 1'b1 || bus_lo.idx_valid !== 1'b0 || bus_lo.load_ready !== 1'b1 ||
            bus_lo.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_done: done=%b vld=%b rdy=%b busy=%b, want 1 0 1 0",
                     bus_lo.done, bus_lo.idx_valid, bus_lo.load_ready, bus_lo.busy);
        end
`ifdef SCHED_ENC_COUNT_EN
        n_chk++;
        if (bus_lo.cnt !== 6'd0) begin
            n_fail++;
            $display("FAIL zero_cnt: got %0d want 0", bus_lo.cnt);
        end
`endif
        @(negedge clk);
        n_chk++;
        if (bus_lo.done !== 1'b0 || bus_lo.idx_valid !== 1'b0 || bus_lo.load_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_after: done=%b vld=%b rdy=%b, want 0 0 1",
                     bus_lo.done, bus_lo.idx_valid, bus_lo.load_ready);
        end
    endtask

    task automatic test_all_ones_high_first();
        bus_hi.load_vec = '1; bus_hi.load_valid = 1; bus_hi.idx_ready = 1;
        @(negedge clk);
        bus_hi.load_valid = 0; bus_hi.load_vec = '0;
        for (int k = 0; k < 32; k++) begin
            n_chk++;
            if (bus_hi.idx_valid !== 1'b1 || bus_hi.idx !== 5'(31 - k) || bus_hi.idx_last !== (k == 31)) begin
                n_fail++;
                $display("FAIL ones_%0d: vld=%b idx=%0d last=%b, want 1 %0d %0d",
                         k, bus_hi.idx_valid, bus_hi.idx, bus_hi.idx_last, 31 - k, (k == 31));
            end
`ifdef SCHED_ENC_COUNT_EN
            n_chk++;
            if (bus_hi.cnt !== 6'(32 - k)) begin
                n_fail++;
                $display("FAIL ones_cnt_%0d: got %0d want %0d", k, bus_hi.cnt, 32 - k);
            end
`endif
            @(negedge clk);
        end
        n_chk++;
        if (bus_hi.done !== 1'b1 || bus_hi.load_ready !== 1'b1 || bus_hi.idx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ones_done: done=%b rdy=%b vld=%b, want 1 1 0",
                     bus_hi.done, bus_hi.load_ready, bus_hi.idx_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_drain();
        logic [0:31] v5;
        v5 = '0; v5[5] = 1'b1;
        bus_lo.load_vec = vec3(); bus_lo.load_valid = 1; bus_lo.idx_ready = 1;
        @(negedge clk);
        bus_lo.load_valid = 0; bus_lo.load_vec = '0;
        n_chk++;
        if (bus_lo.idx !== 5'd3) begin
            n_fail++;
            $display("FAIL mid_first: idx=%0d want 3", bus_lo.idx);
        end
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        n_chk++;
        if (bus_lo.load_ready !== 1'b1 || bus_lo.idx_valid !== 1'b0 || bus_lo.busy !== 1'b0 ||
            bus_lo.done !== 1'b0 || bus_lo.idx !== 5'd0) begin
            n_fail++;
            $display("FAIL mid_reset: rdy=%b vld=%b busy=%b done=%b idx=%0d, want 1 0 0 0 0",
                     bus_lo.load_ready, bus_lo.idx_valid, bus_lo.busy, bus_lo.done, bus_lo.idx);
        end
        bus_lo.load_vec = v5; bus_lo.load_valid = 1;
        @(negedge clk);
        bus_lo.load_valid = 0; bus_lo.load_vec = '0;
        n_chk++;
        if (bus_lo.idx_valid !== 1'b1 || bus_lo.idx !== 5'd5 || bus_lo.idx_last !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_new: vld=%b idx=%0d last=%b, want 1 5 1",
                     bus_lo.idx_valid, bus_lo.idx, bus_lo.idx_last);
        end
        @(negedge clk);
        n_chk++;
        if (bus_lo.done !== 1'b1 || bus_lo.idx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_done: done=%b vld=%b, want 1 0", bus_lo.done, bus_lo.idx_valid);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_drain();
        test_stall();
        test_zero_vec();
        test_all_ones_high_first();
        test_reset_mid_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
